// File: rtl/eyeriss_pe_row_scheduler.sv
// rtl/eyeriss_pe_row_scheduler.sv - row-stationary PE row sequencer: load filters/ifmap, MAC, drain psums
// Optional EYERISS_SCHED_RELU_EN: negative psums drain as zero bytes.
module eyeriss_pe_row_scheduler #(
    parameter int NUM_PE    = 3,
    parameter int FILT_LEN  = 3,
    parameter int IFMAP_LEN = 5,
    parameter int DATA_W    = 8,
    parameter int PSUM_W    = 16,
    localparam int OUT_LEN  = IFMAP_LEN - FILT_LEN + 1,
    localparam int PE_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    localparam int ADDR_W   = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1,
    localparam int K_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1,
    localparam int O_W      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PE_W-1:0]   pe_sel,
    output logic              filt_we,
    output logic              ifmap_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              psum_clr,
    output logic              mac_en,
    output logic [K_W-1:0]    mac_k,
    output logic [O_W-1:0]    mac_o,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [PE_W-1:0]   PE_LAST   = PE_W'(NUM_PE - 1);
    localparam logic [ADDR_W-1:0] FILT_LAST = ADDR_W'(FILT_LEN - 1);
    localparam logic [ADDR_W-1:0] IF_LAST   = ADDR_W'(IFMAP_LEN - 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(FILT_LEN - 1);
    localparam logic [O_W-1:0]    O_LAST    = O_W'(OUT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_FILT, S_LOAD_IFMAP, S_CLR, S_MAC, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [PE_W-1:0]   pe_q, pe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [O_W-1:0]    o_q, o_d;
    logic              byte_q, byte_d;
    logic              in_xfer, out_xfer;
    logic [PSUM_W-1:0] drain_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pe_q    <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            o_q     <= '0;
            byte_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pe_q    <= pe_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            o_q     <= o_d;
            byte_q  <= byte_d;
        end
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pe_d    = pe_q;
        addr_d  = addr_q;
        k_d     = k_q;
        o_d     = o_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_FILT;
            end
            // PE-major filter order: all taps of one PE before moving to the next
            S_LOAD_FILT: begin
                if (in_xfer) begin
                    if (addr_q == FILT_LAST) begin
                        addr_d = '0;
                        if (pe_q == PE_LAST) begin
                            pe_d    = '0;
                            state_d = S_LOAD_IFMAP;
                        end else begin
                            pe_d = pe_q + 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_LOAD_IFMAP: begin
                if (in_xfer) begin
                    if (addr_q == IF_LAST) begin
                        addr_d  = '0;
                        o_d     = '0;
                        state_d = S_CLR;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_CLR: begin
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    pe_d    = '0;
                    byte_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_xfer) begin
                    if (!byte_q) begin
                        byte_d = 1'b1;
                    end else begin
                        byte_d = 1'b0;
                        if (pe_q == PE_LAST) begin
                            pe_d = '0;
                            if (o_q == O_LAST) begin
                                o_d     = '0;
                                state_d = S_IDLE;
                            end else begin
                                o_d     = o_q + 1'b1;
                                state_d = S_CLR;
                            end
                        end else begin
                            pe_d = pe_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef EYERISS_SCHED_RELU_EN
    assign drain_val = psum_in[PSUM_W-1] ? '0 : psum_in;
`else
    assign drain_val = psum_in;
`endif

    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_LOAD_FILT) || (state_q == S_LOAD_IFMAP);
        filt_we   = (state_q == S_LOAD_FILT) && in_valid;
        ifmap_we  = (state_q == S_LOAD_IFMAP) && in_valid;
        wr_addr   = in_ready ? addr_q : '0;
        pe_sel    = ((state_q == S_LOAD_FILT) || (state_q == S_DRAIN)) ? pe_q : '0;
        psum_clr  = (state_q == S_CLR);
        mac_en    = (state_q == S_MAC);
        mac_k     = mac_en ? k_q : '0;
        mac_o     = mac_en ? o_q : '0;
        out_valid = (state_q == S_DRAIN);
        out_data  = '0;
        if (out_valid)
            out_data = byte_q ? drain_val[2*DATA_W-1:DATA_W] : drain_val[DATA_W-1:0];
        done      = out_xfer && byte_q && (pe_q == PE_LAST) && (o_q == O_LAST);
    end

endmodule

// File: tb/tb_eyeriss_pe_row_scheduler.sv
// tb/tb_eyeriss_pe_row_scheduler.sv - directed bench with a behavioural 3-PE array model
module tb_eyeriss_pe_row_scheduler;
    localparam int JOB_CYCLES = 1 + 3*3 + 5 + 3*(1 + 3 + 2*3);

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       busy, done, in_valid = 1'b0, in_ready, filt_we, ifmap_we;
    logic [7:0] in_data = 8'd0, out_data;
    logic [1:0] pe_sel, mac_k, mac_o;
    logic [2:0] wr_addr;
    logic       psum_clr, mac_en, out_valid, out_ready = 1'b0;
    logic [15:0] psum_in;

    int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
    logic [7:0] stream_b [14];
    logic [7:0] exp_b [18];

    eyeriss_pe_row_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pe_sel(pe_sel), .filt_we(filt_we), .ifmap_we(ifmap_we), .wr_addr(wr_addr),
        .psum_clr(psum_clr), .mac_en(mac_en), .mac_k(mac_k), .mac_o(mac_o),
        .psum_in(psum_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        #2;
        if (done) done_cnt++;
    end

    // PE array: filter rows per PE, one broadcast ifmap row, signed psums
    logic signed [7:0]  filt_m [3][3];
    logic signed [7:0]  ifmap_m [5];
    logic signed [15:0] psum_m [3];
    always @(posedge clk) begin
        if (filt_we) filt_m[int'(pe_sel)][int'(wr_addr)] <= in_data;
        if (ifmap_we) ifmap_m[int'(wr_addr)] <= in_data;
        if (psum_clr) for (int p = 0; p < 3; p++) psum_m[p] <= 16'sd0;
        if (mac_en)
            for (int p = 0; p < 3; p++)
                psum_m[p] <= psum_m[p] + filt_m[p][int'(mac_k)] * ifmap_m[int'(mac_o) + int'(mac_k)];
    end
    assign psum_in = psum_m[int'(pe_sel)];

    task automatic set_basic();
        stream_b = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd1,
                     8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp_b = '{8'd6, 8'd0, 8'd14, 8'd0, 8'd3, 8'd0, 8'd9, 8'd0, 8'd20, 8'd0,
                  8'd4, 8'd0, 8'd12, 8'd0, 8'd26, 8'd0, 8'd5, 8'd0};
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, in_ready, pe_sel, filt_we, ifmap_we, wr_addr, psum_clr, mac_en,
             mac_k, mac_o, out_data, out_valid} !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b in_ready=%b pe_sel=%0d we=%b%b wr_addr=%0d clr=%b mac=%b k=%0d o=%0d out=%h ov=%b, required all 0",
                     name, busy, done, in_ready, pe_sel, filt_we, ifmap_we, wr_addr, psum_clr,
                     mac_en, mac_k, mac_o, out_data, out_valid);
        end
    endtask

    task automatic run_job(input bit gaps, input bit poke, input bit abort, output int ncyc);
        int i, j, guard, t0, d0;
        logic [7:0] held;
        bit stalled;
        d0 = done_cnt;
        ncyc = -1;
        held = 8'd0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        i = 0; guard = 0;
        while (i < 14 && guard < 2000) begin
            @(negedge clk); guard++;
            start = (poke && i == 11) ? 1'b1 : 1'b0;
            in_valid = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            in_data = stream_b[i];
            #1;
            if (!in_valid) begin
                checks++;
                if (filt_we || ifmap_we) begin
                    errors++;
                    $display("FAIL strobe_no_valid: filt_we=%b ifmap_we=%b, required 0", filt_we, ifmap_we);
                end
            end
            if (in_valid && in_ready) i++;
        end
        checks++;
        if (i != 14) begin
            errors++;
            $display("FAIL load_timeout: loaded %0d bytes, required 14", i);
        end
        if (abort) begin
            guard = 0;
            while (!mac_en && guard < 50) begin
                @(negedge clk); guard++;
                in_valid = 1'b0; start = 1'b0;
                #1;
            end
            checks++;
            if (!mac_en) begin
                errors++;
                $display("FAIL mac_wait: mac_en=%b, required 1", mac_en);
            end
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            #1;
            check_all_zero("rst_mid_mac");
            rst = 1'b0;
            return;
        end
        j = 0; guard = 0; stalled = 1'b0;
        while (j < 18 && guard < 2000) begin
            @(negedge clk); guard++;
            in_valid = 1'b0;
            start = (poke && j == 3) ? 1'b1 : 1'b0;
            out_ready = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            #1;
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_stable: out_data=%h, required %h", out_data, held);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (out_data !== exp_b[j]) begin
                        errors++;
                        $display("FAIL drain_byte[%0d]: out_data=%h, required %h", j, out_data, exp_b[j]);
                    end
                    if (j == 17) ncyc = cyc - t0 + 1;
                    j++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
        end
        checks++;
        if (j != 18) begin
            errors++;
            $display("FAIL drain_timeout: drained %0d bytes, required 18", j);
        end
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL job_end: busy=%b done_pulses=%0d, required busy=0 done_pulses=1", busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_idle");
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        set_basic();
        run_job(1'b0, 1'b0, 1'b0, n);
        checks++;
        if (n != JOB_CYCLES) begin
            errors++;
            $display("FAIL job_cycles: start..done=%0d cycles, required %0d", n, JOB_CYCLES);
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_basic();
        run_job(1'b1, 1'b0, 1'b0, n);
    endtask

    task automatic test_start_ignored();
        int n;
        set_basic();
        run_job(1'b0, 1'b1, 1'b0, n);
        checks++;
        if (n != JOB_CYCLES) begin
            errors++;
            $display("FAIL start_ignored_cycles: %0d cycles, required %0d", n, JOB_CYCLES);
        end
    endtask

    task automatic test_rst_mid_mac();
        int n;
        set_basic();
        run_job(1'b0, 1'b0, 1'b1, n);
        test_basic();
    endtask

    task automatic test_relu();
        int n;
        set_basic();
        stream_b[3] = 8'hFF; stream_b[4] = 8'hFF; stream_b[5] = 8'hFF;
`ifdef EYERISS_SCHED_RELU_EN
        exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        exp_b[8] = 8'h00; exp_b[9] = 8'h00;
        exp_b[14] = 8'h00; exp_b[15] = 8'h00;
`else
        exp_b[2] = 8'hFA; exp_b[3] = 8'hFF;
        exp_b[8] = 8'hF7; exp_b[9] = 8'hFF;
        exp_b[14] = 8'hF4; exp_b[15] = 8'hFF;
`endif
        run_job(1'b0, 1'b0, 1'b0, n);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_rst_mid_mac();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
